// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store controller for a 256x8 RAM.
// Define MAC_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES without moc.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mfa,
  output logic        ram_rw,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic [1:0]  ram_size,
  input  logic        moc,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        rw_q, rw_d;
  logic        sgn_q, sgn_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mfa_q, mfa_d;
  logic        ram_rw_q, ram_rw_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal;
  logic        expired;
  logic [31:0] load_ext;

  always_comb begin
    unique case (req_size)
      SZ_B:    legal = 1'b1;
      SZ_H:    legal = ~req_addr[0];
      SZ_W:    legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (size_q)
      SZ_B:    load_ext = {{24{sgn_q & ram_dout[7]}},
                           ram_dout[7:0]};
      SZ_H:    load_ext = {{16{sgn_q & ram_dout[15]}},
                           ram_dout[15:0]};
      default: load_ext = ram_dout;
    endcase
  end

`ifdef MAC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != WAIT) begin
      cnt_d = '0;
    end else if (!moc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TO_LAST);
`else
  logic unused_timeout;

  assign unused_timeout = ^TO_LAST;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          state_d = legal ? ISSUE : ERR;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (moc) begin
          state_d = DONE;
          if (rw_q) begin
            rdata_d = load_ext;
          end
        end else if (expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state.
    ready_d  = (state_d == IDLE);
    mfa_d    = (state_d == ISSUE) || (state_d == WAIT);
    ram_rw_d = mfa_d ? rw_d : 1'b1;
    done_d   = (state_d == DONE) || (state_d == ERR);
    err_d    = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rw_q     <= 1'b1;
      sgn_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mfa_q    <= 1'b0;
      ram_rw_q <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      sgn_q    <= sgn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mfa_q    <= mfa_d;
      ram_rw_q <= ram_rw_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mfa       = mfa_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign ram_size  = size_q;

endmodule
